// File: rtl/spi_controller_if.sv
// Write-request handshake and SPI pin bundle for spi_controller.
// master: the requester/bench side; slave: the controller itself.
interface spi_controller_if;
  logic       start;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;
  logic       sclk;
  logic       copi;
  logic       cs_n;

  modport master (
    output start, wr_addr, wr_data,
    input  busy, done, err, sclk, copi, cs_n
  );

  modport slave (
    input  start, wr_addr, wr_data,
    output busy, done, err, sclk, copi, cs_n
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller: 16-bit frame {1'b1, addr[6:0], data[7:0]}, MSB first.
// Optional macro SPI_CTRL_ADDR_CHECK_EN rejects addresses above 4 with an err pulse.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input logic            clk,
  input logic            rst,
  spi_controller_if.slave bus
);

  localparam logic [7:0] HP_RELOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t      state;
  logic [7:0]  hp_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic        sclk_r;
  logic        copi_r;
  logic        cs_n_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic        addr_ok;
  logic        hp_end;

`ifdef SPI_CTRL_ADDR_CHECK_EN
  assign addr_ok = (bus.wr_addr <= 7'd4);
`else
  assign addr_ok = 1'b1;
`endif

  assign hp_end = (hp_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hp_cnt  <= 8'd0;
      bit_cnt <= 4'd0;
      shreg   <= 16'd0;
      sclk_r  <= 1'b0;
      copi_r  <= 1'b0;
      cs_n_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (addr_ok) begin
              state   <= SETUP;
              shreg   <= {1'b1, bus.wr_addr, bus.wr_data};
              hp_cnt  <= HP_RELOAD;
              bit_cnt <= 4'd0;
              cs_n_r  <= 1'b0;
              busy_r  <= 1'b1;
              copi_r  <= 1'b1;
              sclk_r  <= 1'b0;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (hp_end) begin
            state  <= SHIFT;
            sclk_r <= 1'b1;
            hp_cnt <= HP_RELOAD;
          end else begin
            hp_cnt <= hp_cnt - 8'd1;
          end
        end
        SHIFT: begin
          if (hp_end) begin
            hp_cnt <= HP_RELOAD;
            if (sclk_r) begin
              // Falling edge: advance to the next bit, except after bit0 which is held into HOLD.
              sclk_r <= 1'b0;
              if (bit_cnt != 4'd15) begin
                copi_r <= shreg[14];
                shreg  <= {shreg[14:0], 1'b0};
              end
            end else if (bit_cnt == 4'd15) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              sclk_r  <= 1'b1;
            end
          end else begin
            hp_cnt <= hp_cnt - 8'd1;
          end
        end
        HOLD: begin
          if (hp_end) begin
            state  <= GAP;
            cs_n_r <= 1'b1;
            copi_r <= 1'b0;
            done_r <= 1'b1;
            hp_cnt <= HP_RELOAD;
          end else begin
            hp_cnt <= hp_cnt - 8'd1;
          end
        end
        GAP: begin
          if (hp_end) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            hp_cnt <= hp_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk = sclk_r;
  assign bus.copi = copi_r;
  assign bus.cs_n = cs_n_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
`ifdef SPI_CTRL_ADDR_CHECK_EN
  assign bus.err  = err_r;
`else
  assign bus.err  = 1'b0;
`endif

endmodule
